// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-access data memory between two requesters.
//
// M0 (pipeline MEM stage) has fixed priority over M1 (debug/DMA loader). Two
// mechanisms protect M1:
//   - A starvation guard. After M1 has been denied STARVE_LIM consecutive
//     cycles, M1 is forced to win the next arbitration.
//   - A lock mode. M1 keeps ownership across a burst while it holds m1_lock.
// At most one access is granted per cycle. Read data is captured at the
// granting edge into the winner's rdata register, and rvalid pulses for one
// cycle.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   m0_req/we/addr/wdata  M0 request; m0_gnt is combinational
//   m0_rvalid/rdata       M0 read return (registered, 1-cycle latency)
//   m1_req/we/lock/addr/wdata  M1 request (lock keeps ownership); m1_gnt comb.
//   m1_rvalid/rdata       M1 read return (registered, 1-cycle latency)
//   mem_WE/WA/RA/WD       memory drive from the winner (M0 values when idle)
//   mem_RD                memory asynchronous read data
module dmem_arbiter #(
  parameter int unsigned DATA       = 32,
  parameter int unsigned ADDR       = 32,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            m0_req,
  input  logic            m0_we,
  input  logic [ADDR-1:0] m0_addr,
  input  logic [DATA-1:0] m0_wdata,
  output logic            m0_gnt,
  output logic            m0_rvalid,
  output logic [DATA-1:0] m0_rdata,

  input  logic            m1_req,
  input  logic            m1_we,
  input  logic            m1_lock,
  input  logic [ADDR-1:0] m1_addr,
  input  logic [DATA-1:0] m1_wdata,
  output logic            m1_gnt,
  output logic            m1_rvalid,
  output logic [DATA-1:0] m1_rdata,

  output logic            mem_WE,
  output logic [ADDR-1:0] mem_WA,
  output logic [ADDR-1:0] mem_RA,
  output logic [DATA-1:0] mem_WD,
  input  logic [DATA-1:0] mem_RD
);

  localparam logic [7:0] StarveLim = 8'(STARVE_LIM);

  typedef enum logic [0:0] {
    StArb,
    StM1Lock
  } state_e;

  state_e          state_q;
  logic [7:0]      wait_cnt_q;
  logic            m0_rvalid_q;
  logic            m1_rvalid_q;
  logic [DATA-1:0] m0_rdata_q;
  logic [DATA-1:0] m1_rdata_q;

  logic m0_win;
  logic m1_win;
  logic starved;

  // Winner selection. In lock mode M0 is shut out entirely, even if M1 drops
  // its request for a cycle (that cycle releases the lock).
  always_comb begin
    m0_win  = 1'b0;
    m1_win  = 1'b0;
    starved = (wait_cnt_q == StarveLim) && m1_req;
    unique case (state_q)
      StArb: begin
        if (starved) begin
          m1_win = 1'b1;
        end else if (m0_req) begin
          m0_win = 1'b1;
        end else if (m1_req) begin
          m1_win = 1'b1;
        end
      end
      StM1Lock: begin
        m1_win = m1_req;
      end
      default: begin
        m0_win = 1'b0;
        m1_win = 1'b0;
      end
    endcase
  end

  assign m0_gnt = m0_win;
  assign m1_gnt = m1_win;

  // Memory drive. M0 values are the idle default, so only M1 needs a select.
  always_comb begin
    if (m1_win) begin
      mem_WA = m1_addr;
      mem_RA = m1_addr;
      mem_WD = m1_wdata;
      mem_WE = m1_we;
    end else begin
      mem_WA = m0_addr;
      mem_RA = m0_addr;
      mem_WD = m0_wdata;
      mem_WE = m0_win & m0_we;
    end
  end

  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

  // State, starvation counter and read-return registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StArb;
      wait_cnt_q  <= 8'd0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      unique case (state_q)
        StArb: begin
          if (m1_win && m1_lock) begin
            state_q <= StM1Lock;
          end
        end
        StM1Lock: begin
          // The releasing beat is still granted when m1_req is high.
          if (!m1_req || !m1_lock) begin
            state_q <= StArb;
          end
        end
        default: state_q <= StArb;
      endcase

      if (!m1_req || m1_win) begin
        wait_cnt_q <= 8'd0;
      end else if (wait_cnt_q < StarveLim) begin
        wait_cnt_q <= wait_cnt_q + 8'd1;
      end

      m0_rvalid_q <= m0_win & ~m0_we;
      m1_rvalid_q <= m1_win & ~m1_we;
      if (m0_win && !m0_we) begin
        m0_rdata_q <= mem_RD;
      end
      if (m1_win && !m1_we) begin
        m1_rdata_q <= mem_RD;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        mem_WE;
  logic [31:0] mem_WA, mem_RA, mem_WD, mem_RD;

  dmem_arbiter #(
    .DATA      (32),
    .ADDR      (32),
    .STARVE_LIM(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .m0_req   (m0_req),
    .m0_we    (m0_we),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m0_gnt   (m0_gnt),
    .m0_rvalid(m0_rvalid),
    .m0_rdata (m0_rdata),
    .m1_req   (m1_req),
    .m1_we    (m1_we),
    .m1_lock  (m1_lock),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_gnt   (m1_gnt),
    .m1_rvalid(m1_rvalid),
    .m1_rdata (m1_rdata),
    .mem_WE   (mem_WE),
    .mem_WA   (mem_WA),
    .mem_RA   (mem_RA),
    .mem_WD   (mem_WD),
    .mem_RD   (mem_RD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-side memory: written by the DUT's memory drive, cleared on request.
  logic        mem_init;
  logic [31:0] tb_mem [256];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= 32'h0;
    end else if (mem_WE) begin
      tb_mem[mem_WA[7:0]] <= mem_WD;
    end
  end
  assign mem_RD = tb_mem[mem_RA[7:0]];

  // Reference memory, updated from the requesters' own views of their writes.
  logic [31:0] ref_mem [256];

  int total;
  int bad;

  logic        g0, g1, ev0, ev1;
  logic [31:0] ed0, ed1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Mid-cycle: sample grants, predict read returns, apply granted writes to the model.
  task automatic half_a();
    @(negedge clk);
    g0  = m0_gnt;
    g1  = m1_gnt;
    ev0 = g0 && !m0_we;
    ev1 = g1 && !m1_we;
    ed0 = ref_mem[m0_addr[7:0]];
    ed1 = ref_mem[m1_addr[7:0]];
    if (g0 && m0_we) ref_mem[m0_addr[7:0]] = m0_wdata;
    if (g1 && m1_we) ref_mem[m1_addr[7:0]] = m1_wdata;
  endtask

  task automatic half_b();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        m0_req, m0_we;
    logic [31:0] m0_addr, m0_wdata;
    logic        m1_req, m1_we, m1_lock;
    logic [31:0] m1_addr, m1_wdata;
    logic        e_m0_gnt, e_m1_gnt, e_we;
    logic [31:0] e_addr;
    logic        e_m0_rv;
    logic [31:0] e_m0_rd;
    logic        e_m1_rv;
    logic [31:0] e_m1_rd;
  } vec_t;

  function automatic vec_t mk(
    input logic a0r, input logic a0w, input logic [31:0] a0a, input logic [31:0] a0d,
    input logic a1r, input logic a1w, input logic a1l, input logic [31:0] a1a,
    input logic [31:0] a1d, input logic eg0, input logic eg1, input logic ewe,
    input logic [31:0] ea, input logic erv0, input logic [31:0] erd0,
    input logic erv1, input logic [31:0] erd1);
    vec_t v;
    v.m0_req = a0r;  v.m0_we = a0w;  v.m0_addr = a0a;  v.m0_wdata = a0d;
    v.m1_req = a1r;  v.m1_we = a1w;  v.m1_lock = a1l;  v.m1_addr = a1a;
    v.m1_wdata = a1d;
    v.e_m0_gnt = eg0; v.e_m1_gnt = eg1; v.e_we = ewe; v.e_addr = ea;
    v.e_m0_rv = erv0; v.e_m0_rd = erd0; v.e_m1_rv = erv1; v.e_m1_rd = erd1;
    return v;
  endfunction

  vec_t vecs [9];
  logic p0, p1;

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;

    // Expected rdata registers start at 0 after the reset sequence below.
    vecs[0] = mk(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0,            1, 0, 1, 5,
                 0, 32'h0,        0, 32'h0);
    vecs[1] = mk(1, 0, 5, 0,            0, 0, 0, 0, 0,            1, 0, 0, 5,
                 1, 32'hDEADBEEF, 0, 32'h0);
    vecs[2] = mk(0, 0, 7, 0,            0, 0, 0, 0, 0,            0, 0, 0, 7,
                 0, 32'hDEADBEEF, 0, 32'h0);
    vecs[3] = mk(0, 0, 7, 0,            1, 1, 0, 9, 32'h12345678, 0, 1, 1, 9,
                 0, 32'hDEADBEEF, 0, 32'h0);
    vecs[4] = mk(1, 0, 5, 0,            1, 0, 0, 9, 0,            1, 0, 0, 5,
                 1, 32'hDEADBEEF, 0, 32'h0);
    vecs[5] = mk(0, 0, 5, 0,            1, 0, 0, 9, 0,            0, 1, 0, 9,
                 0, 32'hDEADBEEF, 1, 32'h12345678);
    vecs[6] = mk(1, 1, 5, 32'hCAFEF00D, 0, 0, 0, 9, 0,            1, 0, 1, 5,
                 0, 32'hDEADBEEF, 0, 32'h12345678);
    vecs[7] = mk(1, 0, 5, 0,            0, 0, 0, 9, 0,            1, 0, 0, 5,
                 1, 32'hCAFEF00D, 0, 32'h12345678);
    vecs[8] = mk(0, 0, 32'h20, 0,       0, 0, 0, 9, 0,            0, 0, 0, 32'h20,
                 0, 32'hCAFEF00D, 0, 32'h12345678);

    rst = 1'b1;  mem_init = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = 0; m1_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    mem_init = 1'b0;
    check("reset_m0_rvalid", m0_rvalid, 0);
    check("reset_m1_rvalid", m1_rvalid, 0);
    check("reset_m0_rdata", m0_rdata, 0);
    check("reset_m1_rdata", m1_rdata, 0);
    check("reset_gnts", {m0_gnt, m1_gnt}, 0);
    check("reset_mem_we", mem_WE, 0);
    rst = 1'b0;

    // M1 locked read burst, then reset in the middle of it.
    m1_req = 1; m1_we = 0; m1_lock = 1; m1_addr = 3;
    half_a();
    check("lockstart_m1_gnt", m1_gnt, 1);
    check("lockstart_m0_gnt", m0_gnt, 0);
    half_b();
    check("lockstart_m1_rvalid", m1_rvalid, 1);
    m0_req = 1; m0_we = 0; m0_addr = 3;
    half_a();
    check("locked_m0_gnt", m0_gnt, 0);
    check("locked_m1_gnt", m1_gnt, 1);
    #1 rst = 1'b1;
    #1;
    check("midrst_m1_rvalid", m1_rvalid, 0);
    check("midrst_m0_gnt", m0_gnt, 1);
    check("midrst_m1_gnt", m1_gnt, 0);
    half_b();
    check("inrst_m0_rvalid", m0_rvalid, 0);
    check("inrst_m1_rvalid", m1_rvalid, 0);
    rst = 1'b0;
    m0_req = 0; m1_req = 0; m1_lock = 0;

    // Directed vector table.
    for (int i = 0; i < 9; i++) begin
      m0_req = vecs[i].m0_req;  m0_we = vecs[i].m0_we;
      m0_addr = vecs[i].m0_addr; m0_wdata = vecs[i].m0_wdata;
      m1_req = vecs[i].m1_req;  m1_we = vecs[i].m1_we;  m1_lock = vecs[i].m1_lock;
      m1_addr = vecs[i].m1_addr; m1_wdata = vecs[i].m1_wdata;
      half_a();
      check($sformatf("vec%0d_m0_gnt", i), m0_gnt, vecs[i].e_m0_gnt);
      check($sformatf("vec%0d_m1_gnt", i), m1_gnt, vecs[i].e_m1_gnt);
      check($sformatf("vec%0d_mem_we", i), mem_WE, vecs[i].e_we);
      check($sformatf("vec%0d_mem_wa", i), mem_WA, vecs[i].e_addr);
      check($sformatf("vec%0d_mem_ra", i), mem_RA, vecs[i].e_addr);
      half_b();
      check($sformatf("vec%0d_m0_rvalid", i), m0_rvalid, vecs[i].e_m0_rv);
      check($sformatf("vec%0d_m0_rdata", i), m0_rdata, vecs[i].e_m0_rd);
      check($sformatf("vec%0d_m1_rvalid", i), m1_rvalid, vecs[i].e_m1_rv);
      check($sformatf("vec%0d_m1_rdata", i), m1_rdata, vecs[i].e_m1_rd);
    end

    // Starvation: both requesting; M1 forced in every 5th cycle. The second
    // forced grant opens a locked write burst to addresses 0..3.
    m0_req = 1; m0_we = 0; m0_addr = 5;
    for (int i = 0; i < 10; i++) begin
      m1_req = 1;
      if (i <= 4) begin
        m1_we = 0; m1_lock = 0; m1_addr = 9;
      end else begin
        m1_we = 1; m1_lock = 1; m1_addr = 0; m1_wdata = 32'hA0;
      end
      half_a();
      check($sformatf("starve%0d_m1_gnt", i), m1_gnt, (i == 4 || i == 9) ? 1 : 0);
      check($sformatf("starve%0d_m0_gnt", i), m0_gnt, (i == 4 || i == 9) ? 0 : 1);
      half_b();
    end
    for (int b = 1; b < 4; b++) begin
      m1_addr = b; m1_wdata = 32'hA0 + b; m1_lock = (b != 3);
      half_a();
      check($sformatf("burst%0d_m1_gnt", b), m1_gnt, 1);
      check($sformatf("burst%0d_m0_gnt", b), m0_gnt, 0);
      check($sformatf("burst%0d_mem_we", b), mem_WE, 1);
      half_b();
    end
    m1_req = 0; m1_lock = 0; m1_we = 0;
    half_a();
    check("postburst_m0_gnt", m0_gnt, 1);
    half_b();
    check("postburst_m0_rdata", m0_rdata, 32'hCAFEF00D);
    m0_addr = 2;
    half_a();
    half_b();
    check("burst_readback_valid", m0_rvalid, 1);
    check("burst_readback_data", m0_rdata, 32'hA2);
    m0_req = 0;
    half_a();
    check("idle_mem_we", mem_WE, 0);
    half_b();
    check("idle_m0_rvalid", m0_rvalid, 0);
    check("idle_m1_rvalid", m1_rvalid, 0);

    // Random traffic against the reference memory; requests held until granted.
    p0 = 0; p1 = 0; g0 = 1; g1 = 1;
    for (int c = 0; c < 400; c++) begin
      if (!p0 || g0) begin
        m0_req = ($urandom_range(0, 3) != 0);
        m0_we = $urandom_range(0, 1) == 1;
        m0_addr = $urandom_range(0, 15);
        m0_wdata = $urandom;
        p0 = m0_req;
      end
      if (!p1 || g1) begin
        m1_req = ($urandom_range(0, 2) != 0);
        m1_we = $urandom_range(0, 1) == 1;
        m1_lock = ($urandom_range(0, 3) == 0);
        m1_addr = $urandom_range(0, 15);
        m1_wdata = $urandom;
        p1 = m1_req;
      end
      half_a();
      check("rnd_mutex", {31'h0, g0 & g1}, 0);
      if (!m0_req && !m1_req) check("rnd_idle_we", mem_WE, 0);
      half_b();
      check("rnd_m0_rvalid", m0_rvalid, ev0);
      check("rnd_m1_rvalid", m1_rvalid, ev1);
      if (ev0) check("rnd_m0_rdata", m0_rdata, ed0);
      if (ev1) check("rnd_m1_rdata", m1_rdata, ed1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
